tx_fifo_unpack: RTL
===================

// Module: tx_fifo_unpack
// PURPOSE
//  Transmit-side FIFO; the mirror of the receive FIFO. The host pushes 32-bit words.
//  The serial transmitter pops them one byte at a time, least-significant byte first.
//  Depth is 2**ADDR_BITS words. Full/empty use equal pointers plus a wrap-toggle bit.
//  Sits between the host register interface and the byte-serial transmit encoder.
// PARAMETERS
//  ADDR_BITS   2   word-pointer width; depth = 2**ADDR_BITS words (default 4)
// PORTS
//  clk          in   1           system clock, rising edge
//  n_rst        in   1           asynchronous active-low reset
//  write_en     in   1           host push request
//  write_data   in   32          word to push
//  read_en      in   1           transmitter pop request (one byte)
//  read_data    out  8           current head byte; 8'h00 when empty
//  full         out  1           all words occupied
//  empty        out  1           no words occupied
//  mid_word     out  1           head word partially consumed (head_side != 0)
//  word_count   out  ADDR_BITS+1 words occupied, including a partially consumed head word
//  overrun      out  1           registered 1-cycle pulse: push attempted while full
//  underrun     out  1           registered 1-cycle pulse: pop attempted while empty
// BEHAVIOUR
//  - Reset (n_rst=0, async): all state cleared.
//    - tail_ptr, head_ptr, tail_tog, head_tog and head_side = 0.
//    - Outputs: empty=1, full=0, mid_word=0, word_count=0, overrun=0, underrun=0, read_data=0.
//    - Storage is not reset. Reset mid-transfer discards all contents, including a partial word.
//  - Flags are combinational from the current pointers:
//    - empty = (head_ptr==tail_ptr) && (head_tog==tail_tog)
//    - full  = (head_ptr==tail_ptr) && (head_tog!=tail_tog)
//    - word_count = {tail_tog,tail_ptr} - {head_tog,head_ptr}, modulo 2**(ADDR_BITS+1)
//  - Push: write_en && !full. Next edge: mem[tail_ptr] <= write_data; tail_ptr += 1.
//    - On tail_ptr wrap (all-ones -> 0), tail_tog inverts.
//  - Push while full: word dropped, no state change; overrun=1 for the following cycle only.
//  - read_data = mem[head_ptr][8*head_side +: 8] when !empty; zero-latency (combinational).
//  - Pop: read_en && !empty. Next edge: head_side += 1.
//    - When head_side==3: head_side <= 0, head_ptr += 1, and head_tog inverts on wrap.
//    - The word frees only after its 4th byte is popped.
//  - Pop while empty: no state change; underrun=1 for the following cycle only.
//  - Push and pop in the same cycle are evaluated independently against the pre-edge flags.
//    - If full, the push is rejected even when that cycle's pop frees the head word.
//    - If empty, the pop is rejected while the push is accepted.
//  - overrun and underrun may assert in the same cycle. Neither blocks later accepted operations.
// CONFIGURATION
//  TX_FIFO_FLUSH_EN defined:
//    - Adds input port flush (1 bit), synchronous and active-high.
//    - On the edge where flush=1: pointers, toggles and head_side go to 0; overrun/underrun go to 0.
//    - flush has priority over write_en/read_en in the same cycle. Those requests are ignored
//      and raise no error pulse.
//  TX_FIFO_FLUSH_EN undefined: no flush port; contents clear only via n_rst.
// TESTING
//  1. Reset, then push 32'hDDCCBBAA; pop 4 times.
//     -> read_data AA,BB,CC,DD; mid_word 0,1,1,1; then empty=1, word_count=0.
//  2. Push 4 words -> full=1, word_count=4. A 5th push -> overrun=1 for 1 cycle,
//     and the contents are unchanged (pop order verified).
//  3. Pop while empty -> underrun=1 for 1 cycle, read_data=00, pointers unchanged.
//  4. Full FIFO with head_side=3; push+pop in the same cycle.
//     -> push rejected (overrun=1), head word freed, full=0, word_count=3.
//  5. Wrap: push/pop 10 words continuously. Both toggles invert; data is in order;
//     full never asserts with word_count<4.
//  6. Assert n_rst mid-word (head_side=2) -> immediate empty=1, mid_word=0.
//     With TX_FIFO_FLUSH_EN, flush+write_en in the same cycle -> empty=1, no overrun.

Source files
------------

// File: rtl/tx_fifo_unpack.sv
// Transmit FIFO: 32-bit host pushes, byte-wise pops (LSB first), toggle-bit full/empty.
// Optional synchronous flush port enabled by defining TX_FIFO_FLUSH_EN.
module tx_fifo_unpack #(
    parameter int unsigned ADDR_BITS = 2
) (
    input  logic                 clk,
    input  logic                 n_rst,
`ifdef TX_FIFO_FLUSH_EN
    input  logic                 flush,
`endif
    input  logic                 write_en,
    input  logic [31:0]          write_data,
    input  logic                 read_en,
    output logic [7:0]           read_data,
    output logic                 full,
    output logic                 empty,
    output logic                 mid_word,
    output logic [ADDR_BITS:0]   word_count,
    output logic                 overrun,
    output logic                 underrun
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;

    logic [31:0]          mem [DEPTH];
    // Toggle bit kept as the MSB so a plain increment inverts it on pointer wrap.
    logic [ADDR_BITS:0]   tail_cnt;
    logic [ADDR_BITS:0]   head_cnt;
    logic [1:0]           head_side;
    logic [ADDR_BITS-1:0] tail_ptr;
    logic [ADDR_BITS-1:0] head_ptr;
    logic                 tail_tog;
    logic                 head_tog;
    logic                 flush_act;
    logic                 push;
    logic                 pop;

`ifdef TX_FIFO_FLUSH_EN
    assign flush_act = flush;
`else
    assign flush_act = 1'b0;
`endif

    assign tail_ptr = tail_cnt[ADDR_BITS-1:0];
    assign head_ptr = head_cnt[ADDR_BITS-1:0];
    assign tail_tog = tail_cnt[ADDR_BITS];
    assign head_tog = head_cnt[ADDR_BITS];

    always_comb begin
        empty      = (head_ptr == tail_ptr) && (head_tog == tail_tog);
        full       = (head_ptr == tail_ptr) && (head_tog != tail_tog);
        word_count = tail_cnt - head_cnt;
        mid_word   = (head_side != 2'd0);
        push       = write_en && !full && !flush_act;
        pop        = read_en && !empty && !flush_act;
        read_data  = '0;
        if (!empty) begin
            read_data = mem[head_ptr][{head_side, 3'b000} +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail_ptr] <= write_data;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tail_cnt  <= '0;
            head_cnt  <= '0;
            head_side <= '0;
            overrun   <= 1'b0;
            underrun  <= 1'b0;
        end else if (flush_act) begin
            tail_cnt  <= '0;
            head_cnt  <= '0;
            head_side <= '0;
            overrun   <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            overrun  <= write_en && full;
            underrun <= read_en && empty;
            if (push) begin
                tail_cnt <= tail_cnt + 1'b1;
            end
            if (pop) begin
                if (head_side == 2'd3) begin
                    head_side <= '0;
                    head_cnt  <= head_cnt + 1'b1;
                end else begin
                    head_side <= head_side + 2'd1;
                end
            end
        end
    end

endmodule
